// File: rtl/mem_arbiter_2to1.sv
// Two-master to one-slave arbiter for the req/gnt/rvalid memory protocol.
// Round-robin grant, stall lock for address stability, in-order ID FIFO for response routing.
module mem_arbiter_2to1 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    spurious_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] id_fifo;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;
  logic                       last_grant;
  logic                       lock;
  logic                       locked_sel;
  logic                       spurious;

  logic sel;
  logic hold;
  logic pop;
  logic push;
  logic can_push;
  logic head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The lock only binds while its owner keeps requesting, so a master that
  // drops req mid-stall never receives a grant it did not ask for.
  assign hold = lock && (locked_sel ? m1_req_i : m0_req_i);

  always_comb begin
    sel = 1'b0;
    if (hold)                      sel = locked_sel;
    else if (m0_req_i && m1_req_i) sel = ~last_grant;
    else if (m1_req_i)             sel = 1'b1;
    else                           sel = 1'b0;
  end

  assign pop      = s_rvalid_i && (count != '0);
  assign can_push = (count < CNT_MAX) || pop;
  assign s_req_o  = (m0_req_i || m1_req_i) && can_push;
  assign push     = s_req_o && s_gnt_i;
  assign head     = id_fifo[rd_ptr];

  assign m0_gnt_o    = push && !sel;
  assign m1_gnt_o    = push && sel;
  assign m0_rvalid_o = pop && !head;
  assign m1_rvalid_o = pop && head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign spurious_o  = spurious;

  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_fifo    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      lock       <= 1'b0;
      locked_sel <= 1'b0;
      spurious   <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= next_ptr(wr_ptr);
        last_grant      <= sel;
        lock            <= 1'b0;
      end else if (s_req_o) begin
        lock       <= 1'b1;
        locked_sel <= sel;
      end else if (lock && !hold) begin
        lock <= 1'b0;
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (s_rvalid_i && (count == '0)) spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: directed scenarios plus randomized traffic,
// checked per cycle against a queue-based reference model of the arbiter rules.
module tb_mem_arbiter_2to1;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;
  localparam int BUSW = AW + 1 + BW + DW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m1_req_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_we_i, m1_we_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_gnt_i, s_rvalid_i, s_we_o, spurious_o;
  logic [AW-1:0] s_addr_o;
  logic [BW-1:0] s_be_o;
  logic [DW-1:0] s_wdata_o, s_rdata_i;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  // Side-band fields derived from the address so every bus field is distinct per request.
  assign m0_we_i    = m0_addr_i[2];
  assign m1_we_i    = m1_addr_i[2];
  assign m0_be_i    = m0_addr_i[7:4];
  assign m1_be_i    = m1_addr_i[7:4];
  assign m0_wdata_i = m0_addr_i ^ 32'h5a5a_a5a5;
  assign m1_wdata_i = m1_addr_i ^ 32'h5a5a_a5a5;

  mem_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .spurious_o(spurious_o)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic            sreq;
    logic            g0;
    logic            g1;
    logic            rv0;
    logic            rv1;
    logic            spur;
    logic [BUSW-1:0] bus;
    logic [DW-1:0]   rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("s_req", BUSW'(s_req_o), BUSW'(e.sreq));
        check("m0_gnt", BUSW'(m0_gnt_o), BUSW'(e.g0));
        check("m1_gnt", BUSW'(m1_gnt_o), BUSW'(e.g1));
        check("m0_rvalid", BUSW'(m0_rvalid_o), BUSW'(e.rv0));
        check("m1_rvalid", BUSW'(m1_rvalid_o), BUSW'(e.rv1));
        check("spurious", BUSW'(spurious_o), BUSW'(e.spur));
        if (e.sreq) check("s_bus", {s_addr_o, s_we_o, s_be_o, s_wdata_o}, e.bus);
        if (e.rv0)  check("m0_rdata", BUSW'(m0_rdata_o), BUSW'(e.rdata));
        if (e.rv1)  check("m1_rdata", BUSW'(m1_rdata_o), BUSW'(e.rdata));
      end
    end
  end

  // ---------------- reference model ----------------
  bit mdl_ids[$];     // masters of accepted requests awaiting a response, oldest first
  bit mdl_last;       // master granted most recently
  bit mdl_stalled;    // a presented request is waiting for the slave's grant
  bit mdl_stall_id;
  bit mdl_spur;

  function automatic logic [BUSW-1:0] bus_of(input logic [AW-1:0] a);
    return {a, a[2], a[7:4], a ^ 32'h5a5a_a5a5};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_i = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    mdl_ids.delete();
    mdl_last = 1'b1; mdl_stalled = 1'b0; mdl_stall_id = 1'b0; mdl_spur = 1'b0;
  endtask

  task automatic drive_cycle(input bit r0, input bit r1, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1, input bit g, input bit rv,
                             input logic [DW-1:0] rd, output bit eg0, output bit eg1);
    exp_t e;
    bit   sel, pop, acc;
    bit   req[2];
    req[0] = r0; req[1] = r1;
    m0_req_i = r0; m1_req_i = r1; m0_addr_i = a0; m1_addr_i = a1;
    s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
    // A stalled request keeps the slave bus while its owner still asks; otherwise round-robin.
    if (mdl_stalled && req[mdl_stall_id]) sel = mdl_stall_id;
    else if (r0 && r1)                    sel = !mdl_last;
    else                                  sel = r1;
    pop    = rv && (mdl_ids.size() > 0);
    e.sreq = (r0 || r1) && ((mdl_ids.size() < MAXO) || pop);
    acc    = e.sreq && g;
    e.g0   = acc && !sel;
    e.g1   = acc && sel;
    e.rv0  = pop && (mdl_ids[0] == 1'b0);
    e.rv1  = pop && (mdl_ids[0] == 1'b1);
    e.spur = mdl_spur;
    e.bus  = bus_of(sel ? a1 : a0);
    e.rdata = rd;
    exp_q.push_back(e);
    if (rv && mdl_ids.size() == 0) mdl_spur = 1'b1;
    if (pop) void'(mdl_ids.pop_front());
    if (acc) begin
      mdl_ids.push_back(sel);
      mdl_last = sel;
      mdl_stalled = 1'b0;
    end else if (e.sreq) begin
      mdl_stalled = 1'b1;
      mdl_stall_id = sel;
    end else if (mdl_stalled && !req[mdl_stall_id]) begin
      mdl_stalled = 1'b0;
    end
    eg0 = e.g0; eg1 = e.g1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit eg0, eg1;
    bit mreq[2];
    logic [AW-1:0] maddr[2];
    rst_i = 1'b1;
    m0_req_i = 1'b0; m1_req_i = 1'b0; m0_addr_i = '0; m1_addr_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    @(posedge clk); #1;

    // Reset state, then a single m0 read with one-cycle response.
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, eg0, eg1);
    drive_cycle(1, 0, 32'h100, 0, 1, 0, 0, eg0, eg1);
    drive_cycle(0, 0, 32'h100, 0, 0, 1, 32'hdeadbeef, eg0, eg1);

    // Both masters requesting continuously: strict alternation from m0.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive_cycle(1, 1, 32'h1000 + i, 32'h2000 + i, 1, i > 0, $urandom(), eg0, eg1);
    drive_cycle(0, 0, 0, 0, 0, 1, $urandom(), eg0, eg1);

    // Slave stall with m1 selected; m0 joins but the bus stays on m1.
    do_reset();
    drive_cycle(0, 1, 32'h300, 32'h400, 0, 0, 0, eg0, eg1);
    for (int i = 0; i < 2; i++) drive_cycle(1, 1, 32'h300, 32'h400, 0, 0, 0, eg0, eg1);
    drive_cycle(1, 1, 32'h300, 32'h400, 1, 0, 0, eg0, eg1);
    drive_cycle(1, 0, 32'h300, 32'h400, 1, 0, 0, eg0, eg1);
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 0, 0, 1, $urandom(), eg0, eg1);

    // Full FIFO blocks the third request until a response frees a slot.
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 32'h500, 0, 1, 0, 0, eg0, eg1);
    drive_cycle(1, 0, 32'h500, 0, 1, 1, 32'h11112222, eg0, eg1);
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 0, 0, 1, $urandom(), eg0, eg1);

    // rvalid with nothing outstanding sets a sticky flag cleared only by reset.
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 1, 32'h0bad0bad, eg0, eg1);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, eg0, eg1);
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, eg0, eg1);

    // Reset with two requests in flight: late responses are spurious.
    for (int i = 0; i < 2; i++) drive_cycle(1, 0, 32'h600 + i, 0, 1, 0, 0, eg0, eg1);
    do_reset();
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 0, 0, 1, $urandom(), eg0, eg1);
    drive_cycle(1, 0, 32'h200, 0, 1, 0, 0, eg0, eg1);
    drive_cycle(0, 0, 0, 0, 0, 1, 32'hcafef00d, eg0, eg1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, eg0, eg1);

    // Randomized traffic: masters hold req until granted; slave grants and responds at random.
    do_reset();
    mreq[0] = 0; mreq[1] = 0; maddr[0] = '0; maddr[1] = '0;
    for (int c = 0; c < 3000; c++) begin
      drive_cycle(mreq[0], mreq[1], maddr[0], maddr[1], $urandom_range(0, 3) != 0,
                  (mdl_ids.size() > 0) && ($urandom_range(0, 2) != 0), $urandom(), eg0, eg1);
      if (eg0 || (!mreq[0] && $urandom_range(0, 3) == 0)) begin
        mreq[0] = $urandom_range(0, 3) != 0; maddr[0] = $urandom();
      end
      if (eg1 || (!mreq[1] && $urandom_range(0, 3) == 0)) begin
        mreq[1] = $urandom_range(0, 3) != 0; maddr[1] = $urandom();
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, eg0, eg1);
    check("exp_q_drained", BUSW'(exp_q.size()), BUSW'(0));

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
